seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_sat_cnt.sv | 34 +++
 rtl/seq_detect_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_pkg;

    localparam int unsigned SEQ_MAX_LEN = 8;
    localparam logic [SEQ_MAX_LEN-1:0] SEQ_DEF_PAT = 8'b0000_0110;
    localparam int unsigned SEQ_DEF_LEN = 4;
    localparam bit SEQ_DEF_OVL = 1'b1;

    typedef enum logic {
        OvlOff = 1'b0,
        OvlOn  = 1'b1
    } ovl_mode_e;

    // Width able to hold every length 0..max_len inclusive.
    function automatic int unsigned len_w(input int unsigned max_len);
        return unsigned'($clog2(max_len)) + 32'd1;
    endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module seq_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (clr) begin
            w_cnt_next = W'(inc);
        end else if (inc && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int unsigned        MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = SEQ_DEF_PAT,
    parameter int unsigned        DEF_LEN = SEQ_DEF_LEN,
    parameter bit                 DEF_OVL = SEQ_DEF_OVL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       x,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pat,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       cfg_ovl,
    input  logic                       clr_cnt,
    output logic                       z,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cfg_err
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
        $error("seq_detect_param: MAX_LEN must be in 2..32");
    end
    if (DEF_LEN < 1 || DEF_LEN > MAX_LEN) begin : g_bad_def_len
        $error("seq_detect_param: DEF_LEN must be in 1..MAX_LEN");
    end

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    ovl_mode_e          r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_z;
    logic               r_cfg_err;

    logic               w_cfg_ok;
    logic               w_cfg_apply;
    logic               w_cfg_bad;
    logic               w_sample;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    always_comb begin
        w_cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
        w_cfg_apply = cfg_load && w_cfg_ok;
        w_cfg_bad   = cfg_load && !w_cfg_ok;
        // A valid reconfiguration swallows the sample presented in the same cycle.
        w_sample    = en && !w_cfg_apply;
        w_hist_next = {r_hist[MAX_LEN-2:0], x};
        w_fill_inc  = (r_fill == r_len) ? r_fill : r_fill + LEN_W'(1);
        w_mask      = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        w_match = w_sample && (w_fill_inc == r_len) &&
                  (((w_hist_next ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat     <= DEF_PAT;
            r_len     <= LEN_W'(DEF_LEN);
            r_ovl     <= ovl_mode_e'(DEF_OVL);
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_z       <= w_match;
            r_cfg_err <= w_cfg_bad;
            if (w_cfg_apply) begin
                r_pat  <= cfg_pat;
                r_len  <= cfg_len;
                r_ovl  <= ovl_mode_e'(cfg_ovl);
                r_hist <= '0;
                r_fill <= '0;
            end else if (w_sample) begin
                r_hist <= w_hist_next;
                // Non-overlap restarts the fill so no bit serves two matches.
                r_fill <= (w_match && (r_ovl == OvlOff)) ? '0 : w_fill_inc;
            end
        end
    end

    seq_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_match),
        .clr  (clr_cnt),
        .cnt  (match_cnt)
    );

    assign z       = r_z;
    assign cfg_err = r_cfg_err;

endmodule
